bundle_prefetch_queue: RTL and testbench
========================================

Name: bundle_prefetch_queue

Overview:
- Decoupling buffer between main memory's instruction port and instruction_fetch.
- Issues sequential 128-bit bundle reads with a valid/ready request handshake; memory may respond with variable latency, in order.
- Holds up to DEPTH returned bundles tagged with their PC and presents the head bundle to fetch/decode.
- Hazard stall holds the head; a branch redirect flushes the queue and discards stale in-flight responses.

Parameters:
DEPTH, 4, queue entries and maximum outstanding requests (power of two, >=2)
RESET_PC, 32'h0000_0000, first fetch address after reset
BUNDLE_BYTES, 16, PC increment per bundle

Ports:
clk  in  1  clock
rst  in  1  reset; one clock, rst is asynchronous and active-low
mem_req_valid  out  1  bundle read request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  32  bundle address of request
mem_rsp_valid  in  1  response valid (in request order, one per accepted request)
mem_rsp_bundle  in  128  returned bundle
redirect  in  1  branch taken / squash
redirect_pc  in  32  new fetch PC
deq_ready  in  1  consumer takes head this cycle (driven as !stall)
bundle_valid  out  1  head entry valid
bundle_out  out  128  head bundle; 128'h0 when invalid
bundle_pc  out  32  PC of head bundle; 0 when invalid
occupancy  out  $clog2(DEPTH+1)  valid entries held

Behaviour:
- Reset (rst low, async): fetch_pc=RESET_PC, queue empty, inflight=0, drop_cnt=0, all outputs 0.
- Issue: mem_req_valid=1 when !redirect && (occupancy + inflight - drop_cnt) < DEPTH && inflight < DEPTH. mem_req_addr=fetch_pc (registered). Handshake completes when valid&&ready: fetch_pc += BUNDLE_BYTES (wraps mod 2^32), inflight+1. Valid is held with a stable address until accepted or a redirect occurs.
- Response: on mem_rsp_valid with drop_cnt>0, the response is discarded and drop_cnt-1. Otherwise it is written at the tail with tag rsp_pc, and rsp_pc += BUNDLE_BYTES. Either way inflight-1.
- Accept and response in the same cycle leave inflight unchanged.
- A response with inflight==0 is a protocol error: ignored, and an assertion fires.
- Dequeue: head pops when bundle_valid && deq_ready. Head output is combinational from the head entry, so latency from response to bundle_valid is 1 cycle.
- Simultaneous enqueue and dequeue is legal when full: no net change, no overflow. Credit accounting guarantees no enqueue into a full queue.
- Redirect (priority over everything):
  - Queue flushed (occupancy=0) and any dequeue that cycle is ignored.
  - fetch_pc=redirect_pc and rsp_pc=redirect_pc.
  - mem_req_valid forced 0.
  - A response arriving that cycle is discarded.
  - drop_cnt = inflight - mem_rsp_valid. inflight decremented by mem_rsp_valid.
  - First new request issues the next cycle while stale responses drain.
- Redirect while drop_cnt>0: recompute drop_cnt with the same rule; prior drops stay included because inflight counts them.
- Stall (deq_ready=0) with queue full: issue stops, head held stable, no bundle lost.
- Bundle PC alignment is not checked; the low 4 bits pass through.

Decomposition:
- Shared package vliw_pkg: BUNDLE_W=128, ADDR_W=32, NOP_BUNDLE=128'h0, and typedef bundle_entry_t {bundle[127:0], pc[31:0]}.
- One sub-module: sync_fifo (parameterised width/depth, flush, push/pop, count) holds the entries. The top keeps the credit, inflight, drop and PC logic.

Test Plan:
- Reset release, mem_req_ready=1, 1-cycle response latency, deq_ready=1 -> requests to 0x0,0x10,0x20…; bundle_pc follows 0x0,0x10,… one per cycle after fill.
- deq_ready=0 for 20 cycles -> occupancy saturates at 4, mem_req_valid falls to 0, head stays PC 0x0. Release -> PCs 0x0..0x30 emerge in order.
- 3-cycle latency with 3 inflight, then redirect to 0x200 -> 3 stale responses dropped, next bundle_pc=0x200, then 0x210.
- Redirect in the same cycle as a response and deq_ready=1 -> response dropped, occupancy=0, no pop of a flushed entry, first request is 0x(redirect_pc) the next cycle.
- mem_req_ready held 0 for 5 cycles -> mem_req_valid and address stable throughout, no PC advance.
- fetch_pc=0xFFFF_FFF0 -> next request 0x0000_0000. Async reset asserted mid-stream with inflight=2 -> all outputs 0 immediately, and responses arriving after reset release are absent by protocol.

Source files
------------

// File: rtl/vliw_pkg.sv
// Shared widths and the queue entry layout for the instruction-side blocks.
package vliw_pkg;
  localparam int BUNDLE_W = 128;
  localparam int ADDR_W   = 32;
  localparam logic [BUNDLE_W-1:0] NOP_BUNDLE = '0;

  typedef struct packed {
    logic [BUNDLE_W-1:0] bundle;
    logic [ADDR_W-1:0]   pc;
  } bundle_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// Power-of-two circular FIFO with flush; a push into a full FIFO is taken only when a pop frees a slot.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count
);
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic                        do_push, do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/bundle_prefetch_queue.sv
// Sequential bundle prefetcher: credit-limited request issue, in-order response capture,
// redirect flush with stale-response dropping.
module bundle_prefetch_queue
  import vliw_pkg::*;
#(
  parameter  int                DEPTH        = 4,
  parameter  logic [ADDR_W-1:0] RESET_PC     = 32'h0000_0000,
  parameter  int                BUNDLE_BYTES = 16,
  localparam int                CW           = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  input  logic                mem_rsp_valid,
  input  logic [BUNDLE_W-1:0] mem_rsp_bundle,
  input  logic                redirect,
  input  logic [ADDR_W-1:0]   redirect_pc,
  input  logic                deq_ready,
  output logic                bundle_valid,
  output logic [BUNDLE_W-1:0] bundle_out,
  output logic [ADDR_W-1:0]   bundle_pc,
  output logic [CW-1:0]       occupancy
);
  localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(BUNDLE_BYTES);

  logic              active;
  logic [ADDR_W-1:0] fetch_pc, rsp_pc;
  logic [CW-1:0]     inflight, drop_cnt;
  logic [CW:0]       pending;
  logic              req_fire, rsp_ok, rsp_keep, pop;
  bundle_entry_t     head, entry_in;

  // Entries already held plus responses still expected to land in the queue.
  assign pending       = {1'b0, occupancy} + {1'b0, inflight} - {1'b0, drop_cnt};
  assign mem_req_valid = active && !redirect && (pending < (CW+1)'(DEPTH))
                         && (inflight < CW'(DEPTH));
  assign mem_req_addr  = fetch_pc;
  assign req_fire      = mem_req_valid && mem_req_ready;
  assign rsp_ok        = mem_rsp_valid && (inflight != '0);
  assign rsp_keep      = rsp_ok && !redirect && (drop_cnt == '0);
  assign pop           = bundle_valid && deq_ready && !redirect;
  assign entry_in      = '{bundle: mem_rsp_bundle, pc: rsp_pc};

  sync_fifo #(.WIDTH($bits(bundle_entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .push  (rsp_keep),
    .pop   (pop),
    .din   (entry_in),
    .dout  (head),
    .count (occupancy)
  );

  assign bundle_valid = (occupancy != '0);
  assign bundle_out   = bundle_valid ? head.bundle : NOP_BUNDLE;
  assign bundle_pc    = bundle_valid ? head.pc : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active   <= 1'b0;
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      active <= 1'b1;
      if (redirect) begin
        // Every outstanding request not answered this cycle returns stale.
        fetch_pc <= redirect_pc;
        rsp_pc   <= redirect_pc;
        inflight <= inflight - CW'(rsp_ok);
        drop_cnt <= inflight - CW'(rsp_ok);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + PC_INC;
        if (rsp_keep) rsp_pc   <= rsp_pc + PC_INC;
        if (rsp_ok && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
        inflight <= inflight + CW'(req_fire) - CW'(rsp_ok);
      end
    end
  end

  a_rsp_without_req: assert property (@(posedge clk) disable iff (!rst)
    !(mem_rsp_valid && (inflight == '0)));
endmodule

// File: tb/tb_bundle_prefetch_queue.sv
// Directed bench for bundle_prefetch_queue with an in-order variable-latency memory model.
module tb_bundle_prefetch_queue;
  logic         clk = 1'b0;
  logic         rst;
  logic         mem_req_valid, mem_req_ready;
  logic [31:0]  mem_req_addr;
  logic         mem_rsp_valid;
  logic [127:0] mem_rsp_bundle;
  logic         redirect;
  logic [31:0]  redirect_pc;
  logic         deq_ready;
  logic         bundle_valid;
  logic [127:0] bundle_out;
  logic [31:0]  bundle_pc;
  logic [2:0]   occupancy;

  int tests = 0, fails = 0;
  int cyc = 0, lat = 1;
  logic [31:0] rq_addr[$];
  int          rq_due[$];

  bundle_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0), .BUNDLE_BYTES(16)) dut (
    .clk(clk), .rst(rst),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_bundle(mem_rsp_bundle),
    .redirect(redirect), .redirect_pc(redirect_pc), .deq_ready(deq_ready),
    .bundle_valid(bundle_valid), .bundle_out(bundle_out), .bundle_pc(bundle_pc),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] data_of(input logic [31:0] a);
    return {a, ~a, a ^ 32'h1234_5678, 16'hC0DE, a[15:0]};
  endfunction

  // One clock: memory model answers due requests, records accepted ones.
  task automatic tick();
    if (rq_addr.size() > 0 && rq_due[0] <= cyc) begin
      mem_rsp_valid  = 1'b1;
      mem_rsp_bundle = data_of(rq_addr[0]);
      void'(rq_addr.pop_front());
      void'(rq_due.pop_front());
    end else begin
      mem_rsp_valid  = 1'b0;
      mem_rsp_bundle = '0;
    end
    #1;
    if (mem_req_valid && mem_req_ready) begin
      rq_addr.push_back(mem_req_addr);
      rq_due.push_back(cyc + lat);
    end
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_bundle = '0;
    redirect = 1'b0; redirect_pc = '0; deq_ready = 1'b0; lat = 1;
    rq_addr.delete(); rq_due.delete();
    @(posedge clk); #1; @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_bundle = '0;
    redirect = 1'b0; redirect_pc = '0; deq_ready = 1'b1;
    @(posedge clk); #1;
    tests++; if (mem_req_valid !== 1'b0) begin fails++; $display("FAIL reset_req_valid: got %b exp 0", mem_req_valid); end
    tests++; if (mem_req_addr !== 32'h0) begin fails++; $display("FAIL reset_req_addr: got %h exp 0", mem_req_addr); end
    tests++; if (bundle_valid !== 1'b0 || bundle_out !== 128'h0 || bundle_pc !== 32'h0)
      begin fails++; $display("FAIL reset_head: got v=%b pc=%h out=%h exp zeros", bundle_valid, bundle_pc, bundle_out); end
    tests++; if (occupancy !== 3'd0) begin fails++; $display("FAIL reset_occ: got %0d exp 0", occupancy); end
  endtask

  task automatic test_stream();
    do_reset();
    mem_req_ready = 1'b1; deq_ready = 1'b1; lat = 1;
    tick();
    tests++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0)
      begin fails++; $display("FAIL stream_first_req: got v=%b a=%h exp v=1 a=0", mem_req_valid, mem_req_addr); end
    for (int i = 0; i < 8; i++) begin
      tick();
      tests++; if (mem_req_addr !== 32'(i*16 + 16))
        begin fails++; $display("FAIL stream_req_addr[%0d]: got %h exp %h", i, mem_req_addr, 32'(i*16 + 16)); end
      tests++; if (bundle_valid !== (i >= 1))
        begin fails++; $display("FAIL stream_valid[%0d]: got %b exp %b", i, bundle_valid, (i >= 1)); end
      if (i >= 1) begin
        tests++; if (bundle_pc !== 32'((i-1)*16) || bundle_out !== data_of(32'((i-1)*16)))
          begin fails++; $display("FAIL stream_pc[%0d]: got %h exp %h", i, bundle_pc, 32'((i-1)*16)); end
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    mem_req_ready = 1'b1; deq_ready = 1'b0; lat = 1;
    for (int i = 0; i < 21; i++) tick();
    tests++; if (occupancy !== 3'd4) begin fails++; $display("FAIL stall_occ: got %0d exp 4", occupancy); end
    tests++; if (mem_req_valid !== 1'b0) begin fails++; $display("FAIL stall_req_valid: got %b exp 0", mem_req_valid); end
    tests++; if (bundle_pc !== 32'h0 || bundle_valid !== 1'b1)
      begin fails++; $display("FAIL stall_head: got v=%b pc=%h exp v=1 pc=0", bundle_valid, bundle_pc); end
    tests++; if (mem_req_addr !== 32'h40) begin fails++; $display("FAIL stall_addr: got %h exp 40", mem_req_addr); end
    deq_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tests++; if (bundle_valid !== 1'b1 || bundle_pc !== 32'(j*16) || bundle_out !== data_of(32'(j*16)))
        begin fails++; $display("FAIL stall_drain[%0d]: got v=%b pc=%h exp pc=%h", j, bundle_valid, bundle_pc, 32'(j*16)); end
      tick();
    end
  endtask

  task automatic test_redirect_drain();
    do_reset();
    mem_req_ready = 1'b1; deq_ready = 1'b1; lat = 3;
    tick();
    tick(); tick(); tick();
    redirect = 1'b1; redirect_pc = 32'h200; #1;
    tests++; if (mem_req_valid !== 1'b0) begin fails++; $display("FAIL rd_req_forced_low: got %b exp 0", mem_req_valid); end
    tick();
    redirect = 1'b0; #1;
    tests++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h200)
      begin fails++; $display("FAIL rd_new_req: got v=%b a=%h exp v=1 a=200", mem_req_valid, mem_req_addr); end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (bundle_valid !== 1'b0) begin fails++; $display("FAIL rd_stale_drop[%0d]: got v=%b pc=%h exp v=0", i, bundle_valid, bundle_pc); end
    end
    tick();
    tests++; if (bundle_valid !== 1'b1 || bundle_pc !== 32'h200 || bundle_out !== data_of(32'h200))
      begin fails++; $display("FAIL rd_first_pc: got v=%b pc=%h exp 200", bundle_valid, bundle_pc); end
    tick();
    tests++; if (bundle_pc !== 32'h210) begin fails++; $display("FAIL rd_second_pc: got %h exp 210", bundle_pc); end
  endtask

  task automatic test_redirect_same_cycle();
    do_reset();
    mem_req_ready = 1'b1; deq_ready = 1'b1; lat = 1;
    tick(); tick(); tick();
    tests++; if (occupancy !== 3'd1 || bundle_pc !== 32'h0)
      begin fails++; $display("FAIL rs_pre: got occ=%0d pc=%h exp occ=1 pc=0", occupancy, bundle_pc); end
    redirect = 1'b1; redirect_pc = 32'h1000;
    tick();
    redirect = 1'b0; #1;
    tests++; if (occupancy !== 3'd0 || bundle_valid !== 1'b0)
      begin fails++; $display("FAIL rs_flush: got occ=%0d v=%b exp occ=0 v=0", occupancy, bundle_valid); end
    tests++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h1000)
      begin fails++; $display("FAIL rs_new_req: got v=%b a=%h exp v=1 a=1000", mem_req_valid, mem_req_addr); end
    tick(); tick();
    tests++; if (bundle_valid !== 1'b1 || bundle_pc !== 32'h1000)
      begin fails++; $display("FAIL rs_first_pc: got v=%b pc=%h exp 1000", bundle_valid, bundle_pc); end
  endtask

  task automatic test_ready_low();
    do_reset();
    mem_req_ready = 1'b0; deq_ready = 1'b1; lat = 1;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0)
        begin fails++; $display("FAIL hold_req[%0d]: got v=%b a=%h exp v=1 a=0", i, mem_req_valid, mem_req_addr); end
    end
    mem_req_ready = 1'b1;
    tick();
    tests++; if (mem_req_addr !== 32'h10) begin fails++; $display("FAIL hold_release: got %h exp 10", mem_req_addr); end
  endtask

  task automatic test_wrap();
    do_reset();
    mem_req_ready = 1'b0; deq_ready = 1'b1; lat = 1;
    tick();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF0;
    tick();
    redirect = 1'b0; #1;
    tests++; if (mem_req_addr !== 32'hFFFF_FFF0) begin fails++; $display("FAIL wrap_start: got %h exp fffffff0", mem_req_addr); end
    mem_req_ready = 1'b1;
    tick();
    tests++; if (mem_req_addr !== 32'h0) begin fails++; $display("FAIL wrap_addr: got %h exp 0", mem_req_addr); end
    tick();
    tests++; if (bundle_pc !== 32'hFFFF_FFF0) begin fails++; $display("FAIL wrap_head0: got %h exp fffffff0", bundle_pc); end
    tick();
    tests++; if (bundle_valid !== 1'b1 || bundle_pc !== 32'h0)
      begin fails++; $display("FAIL wrap_head1: got v=%b pc=%h exp v=1 pc=0", bundle_valid, bundle_pc); end
  endtask

  task automatic test_async_reset();
    do_reset();
    mem_req_ready = 1'b1; deq_ready = 1'b1; lat = 3;
    tick(); tick(); tick();
    #2; rst = 1'b0; #1;
    tests++; if (mem_req_valid !== 1'b0 || mem_req_addr !== 32'h0)
      begin fails++; $display("FAIL areset_req: got v=%b a=%h exp zeros", mem_req_valid, mem_req_addr); end
    tests++; if (bundle_valid !== 1'b0 || bundle_out !== 128'h0 || bundle_pc !== 32'h0 || occupancy !== 3'd0)
      begin fails++; $display("FAIL areset_head: got v=%b pc=%h occ=%0d exp zeros", bundle_valid, bundle_pc, occupancy); end
    rq_addr.delete(); rq_due.delete();
    @(posedge clk); #1;
    rst = 1'b1; mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    tests++; if (bundle_valid !== 1'b0 || occupancy !== 3'd0)
      begin fails++; $display("FAIL areset_after: got v=%b occ=%0d exp 0", bundle_valid, occupancy); end
    tests++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0)
      begin fails++; $display("FAIL areset_restart: got v=%b a=%h exp v=1 a=0", mem_req_valid, mem_req_addr); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_drain();
    test_redirect_same_cycle();
    test_ready_low();
    test_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
